rf_wb_arbiter: RTL
==================

Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port between NUM_REQ writeback requesters, e.g. ALU writeback (req 0) and load writeback (req 1), using round-robin arbitration.
- Keeps a 32-bit pending-write scoreboard so decode can detect RAW hazards and block WAW issue.
- Sits between the execute/memory stages and the register file. Drives the file's regwrite, write_reg and write_data inputs from a registered output stage.

Parameters:
- NUM_REQ, 2, number of writeback requesters (2..4).
- XLEN, 32, data width.
- REG_AW, 5, register index width (32 registers).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester write request.
- req_ready  out  NUM_REQ  per-requester grant; a handshake completes when valid and ready are both high.
- req_rd  in  NUM_REQ*REG_AW  packed destination indices; requester i occupies bits [i*REG_AW +: REG_AW].
- req_data  in  NUM_REQ*XLEN  packed write data, same packing.
- iss_valid  in  1  decode wants to mark a destination busy.
- iss_rd  in  REG_AW  destination being issued.
- iss_ready  out  1  issue accepted (no WAW conflict).
- rs1, rs2  in  REG_AW each  source indices to check.
- rs1_busy, rs2_busy  out  1 each  a pending write exists to that source.
- rf_regwrite  out  1  register-file write enable.
- rf_write_reg  out  REG_AW  register-file write index.
- rf_write_data  out  XLEN  register-file write data.

Behaviour:
- Reset (async, any cycle, including mid-grant):
  - rf_regwrite=0, rf_write_reg=0, rf_write_data=0.
  - Round-robin pointer set to 0; scoreboard cleared to all zero.
  - req_ready=0 while reset is asserted.
  - An in-flight output-stage write is dropped; the register file is not written.
- Arbitration (combinational within the cycle):
  - Search req_valid starting at the pointer, wrapping modulo NUM_REQ.
  - The first valid requester gets req_ready=1; all others get 0.
  - No valid requesters: no grant, pointer holds.
  - At most one grant per cycle; req_ready never asserts for an invalid requester.
- Pointer update: on a grant to requester g, the pointer becomes (g+1) mod NUM_REQ at the next edge.
- Output stage, 1-cycle latency: a handshake in cycle N yields, in cycle N+1:
  - rf_regwrite=1 (0 if the granted rd==0);
  - rf_write_reg=rd and rf_write_data=data, captured at the N edge.
  - The register file then writes at the edge ending cycle N+1.
  - Without a handshake: rf_regwrite=0; rf_write_reg/rf_write_data hold their last values.
  - The output stage never back-pressures, so throughput is one write per cycle.
- x0:
  - A handshake to rd=0 completes normally but produces no write (rf_regwrite=0).
  - x0 is never marked busy; rs==0 always reports busy=0.
- Scoreboard (sb[31:0], registered):
  - Set: iss_valid && iss_ready && iss_rd!=0 sets sb[iss_rd] at the next edge.
  - Clear: sb[rf_write_reg] is cleared at the edge ending any cycle where rf_regwrite=1 (the commit).
  - Set and clear of the same index at the same edge: set wins, since the new producer is younger.
  - rsX_busy = sb[rsX], combinational from the registered state.
    - Busy becomes visible the cycle after issue.
    - Busy drops in the cycle after commit, when the register file already holds the value, so no bypass is required.
- iss_ready = !(iss_rd!=0 && sb[iss_rd]). The single-outstanding-writer-per-register WAW rule is enforced here.
- A commit whose register is not busy (a requester writing without prior issue) is legal; the clear is then a no-op.
- Requesters must hold req_rd/req_data stable while valid and not ready. The arbiter does not check this.

Decomposition:
- Shared package rf_pkg:
  - constants XLEN=32, REG_AW=5, NUM_REGS=32, REG_ZERO=5'd0;
  - typedef reg_idx_t (logic [REG_AW-1:0]);
  - typedef wb_req_t {rd, data}.
  The register file and decode reuse the same package.
- One natural sub-module, rr_arbiter (parameterised NUM_REQ): valid vector plus pointer in, one-hot grant plus encoded index out.
- Scoreboard and output stage stay in the top module.

Test Plan:
- Reset, then single write: req0 valid, rd=5, data=0xDEADBEEF → req_ready[0]=1 in cycle N; in cycle N+1 rf_regwrite=1, rf_write_reg=5, rf_write_data=0xDEADBEEF; register 5 reads 0xDEADBEEF afterwards.
- Contention fairness: both requesters valid continuously for 6 cycles (req0 rd=1, req1 rd=2) → grants alternate 0,1,0,1,0,1; rf_write_reg sequence 1,2,1,2,1,2; no cycle has two grants.
- x0 suppression: req1 rd=0, data=0x1234 → req_ready[1]=1, rf_regwrite=0 next cycle; register 0 stays 0; rs1=0 gives rs1_busy=0.
- Scoreboard/WAW:
  - Issue rd=7 → rs1=7 busy next cycle.
  - Second issue rd=7 → iss_ready=0.
  - req0 writes rd=7 → busy clears and iss_ready=1 in the cycle after commit.
- Set/clear collision: commit of rd=9 in the same cycle as issue rd=9 (iss_ready high because sb[9] was cleared... set up so rd=9 was committed from a non-issued write) → sb[9]=1 after the edge.
- Async reset mid-grant: assert reset between the handshake and the commit edge → rf_regwrite=0 immediately; target register unchanged; scoreboard all zero; pointer 0 (next contention grants req0 first).

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file definitions used by the writeback arbiter, the
// register file itself and decode.
package rf_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;

    typedef logic [REG_AW-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

    typedef struct packed {
        reg_idx_t          rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: the requester at the pointer has highest priority,
// priority then falls off in increasing index order, wrapping around.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PW-1:0]      grant_idx,
    output logic               grant_valid
);

    // Two passes: indices at or above the pointer first, then the wrapped ones.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_valid && valid[i] && (PW'(i) >= ptr)) begin
                grant[i]    = 1'b1;
                grant_idx   = PW'(i);
                grant_valid = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_valid && valid[i] && (PW'(i) < ptr)) begin
                grant[i]    = 1'b1;
                grant_idx   = PW'(i);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: shares the register file's single write port among
// NUM_REQ requesters and tracks pending writes for hazard detection.
module rf_wb_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int XLEN    = rf_pkg::XLEN,
    parameter int REG_AW  = rf_pkg::REG_AW
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*REG_AW-1:0] req_rd,
    input  logic [NUM_REQ*XLEN-1:0]   req_data,
    input  logic                      iss_valid,
    input  logic [REG_AW-1:0]         iss_rd,
    output logic                      iss_ready,
    input  logic [REG_AW-1:0]         rs1,
    input  logic [REG_AW-1:0]         rs2,
    output logic                      rs1_busy,
    output logic                      rs2_busy,
    output logic                      rf_regwrite,
    output logic [REG_AW-1:0]         rf_write_reg,
    output logic [XLEN-1:0]           rf_write_data
);
    import rf_pkg::*;

    localparam int PW    = $clog2(NUM_REQ);
    localparam int NREGS = 1 << REG_AW;

    logic [PW-1:0]      ptr;
    logic [NUM_REQ-1:0] grant;
    logic [PW-1:0]      grant_idx;
    logic               grant_valid;
    logic [REG_AW-1:0]  win_rd;
    logic [XLEN-1:0]    win_data;
    logic [NREGS-1:0]   sb;
    logic [NREGS-1:0]   sb_next;
    logic               iss_fire;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_rr (
        .valid       (req_valid),
        .ptr         (ptr),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Grants are suppressed while reset is held so no handshake can complete.
    always_comb begin
        req_ready = reset ? '0 : grant;
    end

    // Select the winning requester's destination and data from the packed buses.
    always_comb begin
        win_rd   = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_rd   = req_rd[i*REG_AW +: REG_AW];
                win_data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    // Pointer moves just past the most recent winner.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (grant_valid) begin
            ptr <= (grant_idx == PW'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Output stage: one-cycle registered write; x0 writes complete but never enable.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rf_regwrite   <= 1'b0;
            rf_write_reg  <= '0;
            rf_write_data <= '0;
        end else if (grant_valid) begin
            rf_regwrite   <= (win_rd != '0);
            rf_write_reg  <= win_rd;
            rf_write_data <= win_data;
        end else begin
            rf_regwrite   <= 1'b0;
        end
    end

    assign iss_ready = !((iss_rd != '0) && sb[iss_rd]);
    assign iss_fire  = iss_valid && iss_ready && (iss_rd != '0);
    assign rs1_busy  = sb[rs1];
    assign rs2_busy  = sb[rs2];

    // Commit clears first so a same-edge issue to the same register wins.
    always_comb begin
        sb_next = sb;
        if (rf_regwrite) begin
            sb_next[rf_write_reg] = 1'b0;
        end
        if (iss_fire) begin
            sb_next[iss_rd] = 1'b1;
        end
    end

    // Pending-write scoreboard register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sb <= '0;
        end else begin
            sb <= sb_next;
        end
    end

endmodule
